// File: rtl/w5300_udp_rx_seq.sv
// Receive sequencer for one W5300 UDP socket: polls RX_RSR, reads the UDP info header,
// streams the payload over valid/ready (or drains oversized datagrams) and issues RECV.
module w5300_udp_rx_seq #(
    parameter logic [3:0]  N       = 4'd0,
    parameter logic [15:0] MAX_LEN = 16'd1472
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        bus_req,
    output logic [26:0] bus_cmd,
    input  logic        bus_ack,
    input  logic [15:0] bus_rdata,
    output logic [31:0] peer_ip,
    output logic [15:0] peer_port,
    output logic [15:0] pkt_len,
    output logic        hdr_valid,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        rx_last,
    output logic        done,
    output logic        empty,
    output logic        err
);

    localparam logic [9:0]  SOFF    = {N, 6'b000000};
    localparam logic [9:0]  A_CR    = 10'h202 + SOFF;
    localparam logic [9:0]  A_RSR0  = 10'h228 + SOFF;
    localparam logic [9:0]  A_RSR2  = 10'h22A + SOFF;
    localparam logic [9:0]  A_FIFO  = 10'h230 + SOFF;
    localparam logic [26:0] WR_RECV = {1'b0, A_CR, 16'h0040};

    typedef enum logic [2:0] {
        S_IDLE, S_RSR0, S_RSR2, S_CHECK, S_HDR, S_PAY, S_CMD, S_DONE
    } state_t;

    function automatic logic [15:0] ceil_words(input logic [15:0] len);
        logic [16:0] s;
        s = {1'b0, len} + 17'd1;
        return s[16:1];
    endfunction

    function automatic logic [26:0] rd_cmd(input logic [9:0] addr);
        return {1'b1, addr, 16'h0000};
    endfunction

    state_t      state;
    logic        req_r;
    logic [31:0] rsr;
    logic [1:0]  hcnt;
    logic [15:0] words;
    logic [15:0] widx;
    logic        drain;
    logic        errf;
    logic        kick;
    logic        ack;
    logic        len_zero;
    logic        len_big;
    logic        len_ovr;

    // The next payload read is requested in the very cycle the buffered word is taken,
    // so the buffer never holds more than one word yet a word can move every two cycles.
    assign kick    = (state == S_PAY) && !drain && rx_valid && rx_ready && !rx_last;
    assign bus_req = req_r || kick;
    assign ack     = bus_req && bus_ack;

    always_comb begin
        len_zero = (bus_rdata == 16'd0);
        len_big  = (bus_rdata > MAX_LEN);
        len_ovr  = (({16'h0000, bus_rdata} + 32'd8) > rsr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            req_r     <= 1'b0;
            bus_cmd   <= '0;
            rsr       <= '0;
            peer_ip   <= '0;
            peer_port <= '0;
            pkt_len   <= '0;
            hdr_valid <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_last   <= 1'b0;
            done      <= 1'b0;
            empty     <= 1'b0;
            err       <= 1'b0;
            errf      <= 1'b0;
            drain     <= 1'b0;
            hcnt      <= '0;
            words     <= '0;
            widx      <= '0;
        end else begin
            done      <= 1'b0;
            hdr_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        req_r   <= 1'b1;
                        bus_cmd <= rd_cmd(A_RSR0);
                        empty   <= 1'b0;
                        err     <= 1'b0;
                        errf    <= 1'b0;
                        drain   <= 1'b0;
                        state   <= S_RSR0;
                    end
                end
                S_RSR0: begin
                    if (ack) begin
                        rsr[31:16] <= bus_rdata;
                        bus_cmd    <= rd_cmd(A_RSR2);
                        state      <= S_RSR2;
                    end
                end
                S_RSR2: begin
                    if (ack) begin
                        rsr[15:0] <= bus_rdata;
                        req_r     <= 1'b0;
                        state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (rsr == 32'd0) begin
                        done  <= 1'b1;
                        empty <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        req_r   <= 1'b1;
                        bus_cmd <= rd_cmd(A_FIFO);
                        hcnt    <= 2'd0;
                        state   <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (ack) begin
                        hcnt <= hcnt + 2'd1;
                        case (hcnt)
                            2'd0: peer_ip[31:16] <= bus_rdata;
                            2'd1: peer_ip[15:0]  <= bus_rdata;
                            2'd2: peer_port      <= bus_rdata;
                            default: begin
                                pkt_len   <= bus_rdata;
                                hdr_valid <= 1'b1;
                                words     <= ceil_words(bus_rdata);
                                widx      <= 16'd0;
                                // A bad length or one the FIFO cannot back skips the payload entirely.
                                if (len_zero || len_ovr) begin
                                    errf    <= 1'b1;
                                    bus_cmd <= WR_RECV;
                                    state   <= S_CMD;
                                end else begin
                                    errf  <= len_big;
                                    drain <= len_big;
                                    state <= S_PAY;
                                end
                            end
                        endcase
                    end
                end
                S_PAY: begin
                    if (drain) begin
                        if (ack) begin
                            widx <= widx + 16'd1;
                            if (widx == words - 16'd1) begin
                                bus_cmd <= WR_RECV;
                                state   <= S_CMD;
                            end
                        end
                    end else begin
                        if (rx_valid && rx_ready) begin
                            rx_valid <= 1'b0;
                            rx_last  <= 1'b0;
                            req_r    <= 1'b1;
                            if (rx_last) begin
                                bus_cmd <= WR_RECV;
                                state   <= S_CMD;
                            end
                        end
                        if (ack) begin
                            rx_data  <= bus_rdata;
                            rx_valid <= 1'b1;
                            rx_last  <= (widx == words - 16'd1);
                            widx     <= widx + 16'd1;
                            req_r    <= 1'b0;
                        end
                    end
                end
                S_CMD: begin
                    if (ack) begin
                        req_r <= 1'b0;
                        done  <= 1'b1;
                        err   <= errf;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_w5300_udp_rx_seq.sv
// Bench for w5300_udp_rx_seq: a modelled W5300 bus engine with programmable ack latency,
// a payload scoreboard and a command log compared against the expected access sequence.
module tb_w5300_udp_rx_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        bus_req;
    logic [26:0] bus_cmd;
    logic        bus_ack;
    logic [15:0] bus_rdata;
    logic [31:0] peer_ip;
    logic [15:0] peer_port;
    logic [15:0] pkt_len;
    logic        hdr_valid;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_last;
    logic        done;
    logic        empty;
    logic        err;

    w5300_udp_rx_seq #(.N(4'd0), .MAX_LEN(16'd1472)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .peer_ip(peer_ip), .peer_port(peer_port), .pkt_len(pkt_len), .hdr_valid(hdr_valid),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_last(rx_last),
        .done(done), .empty(empty), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] d;
        logic        l;
    } beat_t;

    localparam logic [26:0] C_RSR0 = {1'b1, 10'h228, 16'h0000};
    localparam logic [26:0] C_RSR2 = {1'b1, 10'h22A, 16'h0000};
    localparam logic [26:0] C_FIFO = {1'b1, 10'h230, 16'h0000};
    localparam logic [26:0] C_RECV = {1'b0, 10'h202, 16'h0040};

    int          checks;
    int          errors;
    int          cyc;
    int          dly;
    int          cnt;
    logic [26:0] held_cmd;
    logic [15:0] fifo[$];
    logic [31:0] rsr_m;
    logic [26:0] cmd_log[$];
    logic [26:0] exp_cmd[$];
    beat_t       sb[$];
    beat_t       b;
    bit          done_seen;
    logic        done_empty;
    logic        done_err;
    bit          hdr_seen;
    logic [31:0] hdr_ip;
    logic [15:0] hdr_port;
    logic [15:0] hdr_len;
    int          beat;
    int          last_hs;
    int          gap_max;
    int          rxv_cnt;
    bit          stall_on;
    int          stall_cnt;
    logic [15:0] held_data;

    function automatic int log_diff();
        if (cmd_log.size() != exp_cmd.size()) return -2;
        foreach (cmd_log[i]) if (cmd_log[i] !== exp_cmd[i]) return i;
        return -1;
    endfunction

    task automatic exp_seq(input int nfifo, input bit recv);
        exp_cmd.delete();
        exp_cmd.push_back(C_RSR0);
        exp_cmd.push_back(C_RSR2);
        repeat (nfifo) exp_cmd.push_back(C_FIFO);
        if (recv) exp_cmd.push_back(C_RECV);
    endtask

    task automatic load_pkt(input logic [31:0] ip, input logic [15:0] port, input logic [15:0] len,
                            input logic [31:0] rsr, input int nwords, input bit deliver);
        logic [15:0] w;
        fifo.delete();
        sb.delete();
        rsr_m = rsr;
        fifo.push_back(ip[31:16]);
        fifo.push_back(ip[15:0]);
        fifo.push_back(port);
        fifo.push_back(len);
        for (int i = 0; i < nwords; i++) begin
            w = 16'(i * 16'h1357 + 16'hA1B2);
            fifo.push_back(w);
            if (deliver) sb.push_back('{d: w, l: (i == nwords - 1)});
        end
    endtask

    task automatic do_start();
        cmd_log.delete();
        done_seen = 0;
        hdr_seen  = 0;
        beat      = 0;
        gap_max   = 0;
        rxv_cnt   = 0;
        stall_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, input string name);
        for (int i = 0; i < lim && !done_seen; i++) @(negedge clk);
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL %s_timeout: done=0 after %0d cycles, required done pulse", name, lim);
        end
        @(negedge clk);
        #2;
        checks++;
        if (busy !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b bus_req=%b, required 0/0", name, busy, bus_req);
        end
    endtask

    // Sink, header/done capture and bus-engine model in one process to keep ordering deterministic.
    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (rx_valid) rxv_cnt++;
            if (rx_valid && stall_on && beat == 1 && stall_cnt < 10) begin
                if (stall_cnt == 0) held_data = rx_data;
                else begin
                    checks++;
                    if (rx_data !== held_data || bus_req !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_hold: rx_data=%h bus_req=%b, required %h/0", rx_data, bus_req, held_data);
                    end
                end
                rx_ready = 1'b0;
                stall_cnt++;
            end else begin
                rx_ready = 1'b1;
            end
            if (rx_valid && rx_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rx_unexpected: got word %h last=%b, required no word", rx_data, rx_last);
                end else begin
                    b = sb.pop_front();
                    if (rx_data !== b.d || rx_last !== b.l) begin
                        errors++;
                        $display("FAIL rx_word%0d: got %h last=%b, required %h last=%b", beat, rx_data, rx_last, b.d, b.l);
                    end
                end
                if (beat > 0 && cyc - last_hs > gap_max) gap_max = cyc - last_hs;
                last_hs = cyc;
                beat++;
            end
            if (done) begin
                done_seen  = 1;
                done_empty = empty;
                done_err   = err;
            end
            if (hdr_valid) begin
                hdr_seen = 1;
                hdr_ip   = peer_ip;
                hdr_port = peer_port;
                hdr_len  = pkt_len;
            end
            #1;
            if (rst) begin
                bus_ack = 1'b0;
                cnt     = 0;
            end else begin
                if (bus_ack) cnt = 0;
                bus_ack = 1'b0;
                if (bus_req) begin
                    cnt++;
                    if (cnt == 1) held_cmd = bus_cmd;
                    else begin
                        checks++;
                        if (bus_cmd !== held_cmd) begin
                            errors++;
                            $display("FAIL cmd_stable: bus_cmd=%h, required %h until ack", bus_cmd, held_cmd);
                        end
                    end
                    if (cnt >= dly) begin
                        bus_ack = 1'b1;
                        cmd_log.push_back(bus_cmd);
                        case (bus_cmd[25:16])
                            10'h228: bus_rdata = rsr_m[31:16];
                            10'h22A: bus_rdata = rsr_m[15:0];
                            10'h230: bus_rdata = (fifo.size() > 0) ? fifo.pop_front() : 16'hDEAD;
                            default: bus_rdata = 16'h0000;
                        endcase
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, bus_req, bus_cmd, hdr_valid, rx_valid, rx_last, done, empty, err} !== '0 || peer_ip !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b req=%b cmd=%h valid=%b done=%b, required all 0", busy, bus_req, bus_cmd, rx_valid, done);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b bus_req=%b, required 0/0", busy, bus_req);
        end
    endtask

    task automatic test_empty(input string name);
        load_pkt(32'd0, 16'd0, 16'd0, 32'd0, 0, 0);
        fifo.delete();
        exp_seq(0, 0);
        do_start();
        wait_done(100, name);
        checks++;
        if (done_empty !== 1'b1 || done_err !== 1'b0) begin
            errors++;
            $display("FAIL %s_flags: empty=%b err=%b, required 1/0", name, done_empty, done_err);
        end
        checks++;
        if (log_diff() != -1) begin
            errors++;
            $display("FAIL %s_seq: %0d commands logged, diff at %0d, required RSR0,RSR2 only", name, cmd_log.size(), log_diff());
        end
    endtask

    task automatic test_basic();
        load_pkt(32'hC0A80101, 16'h1F90, 16'd5, 32'd13, 3, 1);
        exp_seq(7, 1);
        do_start();
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, "basic");
        checks++;
        if (!hdr_seen || hdr_ip !== 32'hC0A80101 || hdr_port !== 16'd8080 || hdr_len !== 16'd5) begin
            errors++;
            $display("FAIL basic_hdr: seen=%b ip=%h port=%0d len=%0d, required C0A80101/8080/5", hdr_seen, hdr_ip, hdr_port, hdr_len);
        end
        checks++;
        if (beat != 3 || sb.size() != 0 || done_err !== 1'b0 || done_empty !== 1'b0) begin
            errors++;
            $display("FAIL basic_payload: words=%0d left=%0d err=%b empty=%b, required 3/0/0/0", beat, sb.size(), done_err, done_empty);
        end
        checks++;
        if (gap_max != 2) begin
            errors++;
            $display("FAIL basic_rate: max gap %0d cycles, required 2", gap_max);
        end
        checks++;
        if (log_diff() != -1) begin
            errors++;
            $display("FAIL basic_seq: %0d commands, diff at %0d, required RSR0,RSR2,7xFIFO,RECV", cmd_log.size(), log_diff());
        end
    endtask

    task automatic test_backpressure();
        load_pkt(32'hC0A80101, 16'h1F90, 16'd5, 32'd13, 3, 1);
        exp_seq(7, 1);
        stall_on = 1;
        do_start();
        wait_done(300, "stall");
        stall_on = 0;
        checks++;
        if (stall_cnt != 10 || beat != 3 || sb.size() != 0) begin
            errors++;
            $display("FAIL stall_flow: stalled %0d words %0d left %0d, required 10/3/0", stall_cnt, beat, sb.size());
        end
        checks++;
        if (log_diff() != -1) begin
            errors++;
            $display("FAIL stall_seq: %0d commands, diff at %0d, required 10 commands", cmd_log.size(), log_diff());
        end
    endtask

    task automatic test_drain();
        load_pkt(32'h0A000002, 16'h0050, 16'd2000, 32'd2008, 1000, 0);
        exp_seq(1004, 1);
        do_start();
        wait_done(5000, "drain");
        checks++;
        if (done_err !== 1'b1 || rxv_cnt != 0 || hdr_len !== 16'd2000) begin
            errors++;
            $display("FAIL drain_flags: err=%b rx_valid cycles=%0d len=%0d, required 1/0/2000", done_err, rxv_cnt, hdr_len);
        end
        checks++;
        if (log_diff() != -1 || fifo.size() != 0) begin
            errors++;
            $display("FAIL drain_seq: %0d commands, diff at %0d, fifo left %0d, required 1007/-1/0", cmd_log.size(), log_diff(), fifo.size());
        end
    endtask

    task automatic test_hdr_err(input logic [15:0] len, input logic [31:0] rsr, input string name);
        load_pkt(32'h0A000003, 16'h1234, len, rsr, 0, 0);
        exp_seq(4, 1);
        do_start();
        wait_done(200, name);
        checks++;
        if (done_err !== 1'b1 || rxv_cnt != 0 || log_diff() != -1) begin
            errors++;
            $display("FAIL %s: err=%b rx_valid cycles=%0d seq diff %0d, required 1/0/-1", name, done_err, rxv_cnt, log_diff());
        end
    endtask

    task automatic test_max_len();
        load_pkt(32'h0A000004, 16'h4321, 16'd1472, 32'd1480, 736, 1);
        exp_seq(740, 1);
        do_start();
        wait_done(4000, "maxlen");
        checks++;
        if (done_err !== 1'b0 || beat != 736 || sb.size() != 0 || log_diff() != -1) begin
            errors++;
            $display("FAIL maxlen: err=%b words=%0d left=%0d diff=%0d, required 0/736/0/-1", done_err, beat, sb.size(), log_diff());
        end
    endtask

    task automatic test_ack_delay();
        dly = 6;
        load_pkt(32'hC0A80101, 16'h1F90, 16'd5, 32'd13, 3, 1);
        exp_seq(7, 1);
        do_start();
        wait_done(400, "slowack");
        dly = 2;
        checks++;
        if (beat != 3 || sb.size() != 0 || done_err !== 1'b0 || log_diff() != -1) begin
            errors++;
            $display("FAIL slowack: words=%0d left=%0d err=%b diff=%0d, required 3/0/0/-1", beat, sb.size(), done_err, log_diff());
        end
    endtask

    task automatic test_reset_mid();
        load_pkt(32'hC0A80101, 16'h1F90, 16'd5, 32'd13, 3, 1);
        stall_on = 1;
        do_start();
        for (int i = 0; i < 200 && stall_cnt < 3; i++) @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, bus_req, rx_valid, rx_last, done, hdr_valid} !== '0 || rx_data !== 16'd0 || bus_cmd !== 27'd0) begin
            errors++;
            $display("FAIL midreset_outputs: busy=%b req=%b valid=%b data=%h cmd=%h, required all 0", busy, bus_req, rx_valid, rx_data, bus_cmd);
        end
        stall_on = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        test_empty("midreset_restart");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        cnt       = 0;
        dly       = 2;
        rst       = 1'b1;
        start     = 1'b0;
        rx_ready  = 1'b1;
        bus_ack   = 1'b0;
        bus_rdata = 16'h0000;
        stall_on  = 0;
        stall_cnt = 0;
        rsr_m     = 32'd0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        test_reset();
        test_empty("empty");
        test_basic();
        test_backpressure();
        test_drain();
        test_hdr_err(16'd0, 32'd8, "len_zero");
        test_hdr_err(16'd5, 32'd12, "len_over_rsr");
        test_max_len();
        test_ack_delay();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
